// File: rtl/mc_pkg.sv
// mc_pkg: sequencer state codes, instruction-class encodings and the PC step
// shared by the multicycle datapath and its sequencer.
package mc_pkg;
    localparam logic [2:0] FETCH   = 3'd0;
    localparam logic [2:0] DECODE  = 3'd1;
    localparam logic [2:0] EXECUTE = 3'd2;
    localparam logic [2:0] MEMRD   = 3'd3;
    localparam logic [2:0] MEMWR   = 3'd4;
    localparam logic [2:0] WB      = 3'd5;
    localparam logic [2:0] HALT    = 3'd6;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_UND = 2'b11;

    localparam int unsigned PC_INC = 4;

    function automatic logic is_mem_state(input logic [2:0] s);
        return (s == MEMRD) || (s == MEMWR);
    endfunction
endpackage

// File: rtl/alu.sv
// alu: add/sub/and/or/xor/pass-B with NZCV flags; C and V only for add/sub.
module alu #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [2:0]      ctrl_i,
    output logic [XLEN-1:0] result_o,
    output logic [3:0]      flags_o
);
    logic            sub;
    logic            arith;
    logic [XLEN-1:0] b_eff;
    logic [XLEN:0]   sum;

    assign sub   = (ctrl_i == 3'b001);
    assign arith = (ctrl_i[2:1] == 2'b00);
    assign b_eff = sub ? ~b_i : b_i;
    assign sum   = {1'b0, a_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, sub};

    always_comb begin
        case (ctrl_i)
            3'b000, 3'b001: result_o = sum[XLEN-1:0];
            3'b010:         result_o = a_i & b_i;
            3'b011:         result_o = a_i | b_i;
            3'b100:         result_o = a_i ^ b_i;
            default:        result_o = b_i;
        endcase
    end

    assign flags_o = {result_o[XLEN-1],
                      result_o == '0,
                      arith & sum[XLEN],
                      arith & (a_i[XLEN-1] == b_eff[XLEN-1]) & (result_o[XLEN-1] != a_i[XLEN-1])};
endmodule

// File: rtl/extend.sv
// extend: immediate extension -- 00 zero imm8, 01 zero imm12,
// 10 signed word-scaled imm24 branch offset, 11 signed imm12.
module extend #(
    parameter int XLEN = 32
) (
    input  logic [23:0]     instr_i,
    input  logic [1:0]      imm_src_i,
    output logic [XLEN-1:0] ext_imm_o
);
    logic signed [25:0] br_off;
    logic signed [11:0] imm12_s;

    assign br_off  = signed'({instr_i, 2'b00});
    assign imm12_s = signed'(instr_i[11:0]);

    always_comb begin
        case (imm_src_i)
            2'b00:   ext_imm_o = {{(XLEN-8){1'b0}}, instr_i[7:0]};
            2'b01:   ext_imm_o = {{(XLEN-12){1'b0}}, instr_i[11:0]};
            2'b10:   ext_imm_o = {{(XLEN-26){br_off[25]}}, br_off};
            default: ext_imm_o = {{(XLEN-12){imm12_s[11]}}, imm12_s};
        endcase
    end
endmodule

// File: rtl/mc_seq.sv
// mc_seq: multicycle sequencer FSM with sticky fault. Defining WAIT_TIMEOUT_EN
// adds a consecutive-unready counter that halts after MAX_WAIT cycles.
module mc_seq
    import mc_pkg::*;
#(
    parameter int MAX_WAIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op_i,
    input  logic       is_load_i,
    input  logic       cond_pass_i,
    input  logic       mem_ready_i,
    output logic [2:0] state_o,
    output logic       fault_o
);
    logic [2:0] state_q, state_d;
    logic       fault_q, fault_d;

`ifdef WAIT_TIMEOUT_EN
    localparam int WW = $clog2(MAX_WAIT + 1);
    logic [WW-1:0] wait_q, wait_d;
    logic          waiting;
    logic          timeout;

    assign waiting = ((state_q == FETCH) || is_mem_state(state_q)) && !mem_ready_i;
    assign timeout = waiting && (wait_q == WW'(MAX_WAIT - 1));
    assign wait_d  = waiting ? wait_q + WW'(1) : '0;

    always_ff @(posedge clk) begin
        if (reset) wait_q <= '0;
        else       wait_q <= wait_d;
    end
`else
    logic timeout;
    logic unused_max_wait;
    assign timeout         = 1'b0;
    assign unused_max_wait = ^MAX_WAIT;
`endif

    always_comb begin
        state_d = state_q;
        fault_d = fault_q;
        case (state_q)
            FETCH:   if (mem_ready_i) state_d = DECODE;
            DECODE: begin
                if (op_i == OP_UND) begin
                    state_d = HALT;
                    fault_d = 1'b1;
                end else if (!cond_pass_i) begin
                    state_d = FETCH;
                end else begin
                    state_d = EXECUTE;
                end
            end
            EXECUTE: begin
                case (op_i)
                    OP_DP:   state_d = WB;
                    OP_MEM:  state_d = is_load_i ? MEMRD : MEMWR;
                    default: state_d = FETCH;
                endcase
            end
            MEMRD:   if (mem_ready_i) state_d = WB;
            MEMWR:   if (mem_ready_i) state_d = FETCH;
            WB:      state_d = FETCH;
            HALT:    state_d = HALT;
            default: state_d = HALT;
        endcase
        if (timeout) begin
            state_d = HALT;
            fault_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FETCH;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_d;
        end
    end

    assign state_o = state_q;
    assign fault_o = fault_q;
endmodule

// File: rtl/mc_datapath.sv
// mc_datapath: multicycle datapath top -- Instr/PC registers, register file with
// PC alias, operand latches, memory port. WAIT_TIMEOUT_EN enables the wait timeout.
module mc_datapath
    import mc_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NREG     = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      op,
    input  logic            is_load,
    input  logic            cond_pass,
    input  logic [1:0]      RegSrc,
    input  logic [1:0]      ImmSrc,
    input  logic            ALUSrc,
    input  logic [2:0]      ALUControl,
    input  logic            MemtoReg,
    input  logic            RegWrite,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ready,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic            mem_req,
    output logic            mem_we,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [3:0]      ALUFlags,
    output logic [2:0]      state,
    output logic            fault
);
    localparam int RW = $clog2(NREG);
    localparam logic [RW-1:0] PC_IDX = RW'(NREG - 1);

    logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
    logic [31:0]     instr_q;
    logic [3:0]      flags_q;
    logic [XLEN-1:0] a_q, b_q, aluout_q, data_q;
    logic [XLEN-1:0] rf [NREG];
    logic [RW-1:0]   ra1, ra2, rd_idx;
    logic [XLEN-1:0] rd1, rd2, ext_imm, src_b, alu_result, result;
    logic [3:0]      alu_flags;
    logic            wb_we;

    mc_seq #(.MAX_WAIT(MAX_WAIT)) u_seq (
        .clk         (clk),
        .reset       (reset),
        .op_i        (op),
        .is_load_i   (is_load),
        .cond_pass_i (cond_pass),
        .mem_ready_i (mem_ready),
        .state_o     (state),
        .fault_o     (fault)
    );

    // Register reads of the PC alias see PC+4, i.e. instruction address + 8.
    assign pc_plus4 = pc_q + XLEN'(PC_INC);
    assign ra1      = RegSrc[0] ? PC_IDX : instr_q[16 +: RW];
    assign ra2      = RegSrc[1] ? instr_q[12 +: RW] : instr_q[0 +: RW];
    assign rd_idx   = instr_q[12 +: RW];
    assign rd1      = (ra1 == PC_IDX) ? pc_plus4 : rf[ra1];
    assign rd2      = (ra2 == PC_IDX) ? pc_plus4 : rf[ra2];

    extend #(.XLEN(XLEN)) u_ext (
        .instr_i   (instr_q[23:0]),
        .imm_src_i (ImmSrc),
        .ext_imm_o (ext_imm)
    );

    assign src_b = ALUSrc ? ext_imm : b_q;

    alu #(.XLEN(XLEN)) u_alu (
        .a_i      (a_q),
        .b_i      (src_b),
        .ctrl_i   (ALUControl),
        .result_o (alu_result),
        .flags_o  (alu_flags)
    );

    assign result = MemtoReg ? data_q : aluout_q;
    assign wb_we  = (state == WB) && RegWrite && !reset;

    always_comb begin
        pc_d = pc_q;
        if ((state == FETCH) && mem_ready)       pc_d = pc_plus4;
        if ((state == EXECUTE) && (op == OP_BR)) pc_d = alu_result;
        if (wb_we && (rd_idx == PC_IDX))         pc_d = result;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= '0;
            instr_q <= '0;
            flags_q <= '0;
        end else begin
            pc_q <= pc_d;
            if ((state == FETCH) && mem_ready) instr_q <= mem_rdata[31:0];
            if (state == EXECUTE)              flags_q <= alu_flags;
        end
    end

    always_ff @(posedge clk) begin
        if (state == DECODE) begin
            a_q <= rd1;
            b_q <= rd2;
        end
        if (state == EXECUTE)             aluout_q   <= alu_result;
        if ((state == MEMRD) && mem_ready) data_q    <= mem_rdata;
        if (wb_we && (rd_idx != PC_IDX))  rf[rd_idx] <= result;
    end

    // Requests are held off while reset is asserted, even though state reads FETCH.
    assign mem_req   = ((state == FETCH) || is_mem_state(state)) && !reset;
    assign mem_we    = (state == MEMWR) && !reset;
    assign mem_addr  = is_mem_state(state) ? aluout_q : pc_q;
    assign mem_wdata = b_q;
    assign Instr     = instr_q;
    assign PC        = pc_q;
    assign ALUFlags  = flags_q;
endmodule

// File: tb/tb_mc_datapath.sv
// tb_mc_datapath: directed instruction sequence against mc_datapath with
// hand-computed register, PC, flag, latency and memory-port expectations.
module tb_mc_datapath;
    localparam int XLEN = 32;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_MEMRD = 3'd3,
                           S_MEMWR = 3'd4, S_WB = 3'd5, S_HALT = 3'd6;

    logic            clk = 1'b0;
    logic            reset;
    logic [1:0]      op;
    logic            is_load, cond_pass;
    logic [1:0]      RegSrc, ImmSrc;
    logic            ALUSrc;
    logic [2:0]      ALUControl;
    logic            MemtoReg, RegWrite;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_ready;
    logic [XLEN-1:0] mem_addr, mem_wdata;
    logic            mem_req, mem_we;
    logic [31:0]     Instr;
    logic [XLEN-1:0] PC;
    logic [3:0]      ALUFlags;
    logic [2:0]      state;
    logic            fault;

    int              n_assert = 0;
    int              n_fail = 0;
    int              ncyc;
    logic            saw_we, saw_wb, addr_moved;
    logic [XLEN-1:0] addr_seen, wdata_seen;

    mc_datapath #(.XLEN(XLEN), .NREG(16), .MAX_WAIT(15)) dut (
        .clk(clk), .reset(reset), .op(op), .is_load(is_load), .cond_pass(cond_pass),
        .RegSrc(RegSrc), .ImmSrc(ImmSrc), .ALUSrc(ALUSrc), .ALUControl(ALUControl),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_req(mem_req), .mem_we(mem_we), .Instr(Instr), .PC(PC),
        .ALUFlags(ALUFlags), .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ctl(input logic [1:0] o, input logic ld, input logic cp,
                           input logic [1:0] rs, input logic [1:0] is, input logic as,
                           input logic [2:0] ac, input logic m2r, input logic rw);
        op = o; is_load = ld; cond_pass = cp; RegSrc = rs; ImmSrc = is;
        ALUSrc = as; ALUControl = ac; MemtoReg = m2r; RegWrite = rw;
    endtask

    // Runs one instruction from FETCH until the sequencer returns to FETCH (or halts).
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic [XLEN-1:0] rdata, output int n);
        int w;
        logic [2:0] prev;
        logic left;
        n = 0; w = 0; left = 1'b0;
        saw_we = 1'b0; saw_wb = 1'b0; addr_moved = 1'b0;
        addr_seen = '0; wdata_seen = '0;
        prev = state;
        while (n < 40 && !(left && state == S_FETCH) && state != S_HALT) begin
            mem_ready = 1'b0;
            if (state == S_FETCH) begin
                mem_rdata = ins;
                mem_ready = (w >= fw);
            end else if (state == S_MEMRD || state == S_MEMWR) begin
                mem_rdata = rdata;
                mem_ready = (w >= mw);
                if (w == 0) addr_seen = mem_addr;
                else if (mem_addr !== addr_seen) addr_moved = 1'b1;
            end
            if (mem_we) begin
                saw_we = 1'b1;
                wdata_seen = mem_wdata;
            end
            if (state == S_WB) saw_wb = 1'b1;
            cyc();
            n++;
            if (state != S_FETCH) left = 1'b1;
            w = (state == prev) ? w + 1 : 0;
            prev = state;
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; mem_rdata = '0; mem_ready = 1'b0;
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        cyc(); cyc();
        chk("rst_state", state, S_FETCH);
        chk("rst_pc", PC, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_flags", ALUFlags, 0);
        chk("rst_fault", fault, 0);
        chk("rst_req", mem_req, 0);
        reset = 1'b0;
        #1;
        chk("fetch_req", mem_req, 1);
        chk("fetch_addr", mem_addr, 0);

        // MOV r2,#5 and MOV r3,#7, then reset: register file keeps its contents
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 3'b101, 1'b0, 1'b1);
        run_instr(32'h0000_2005, 0, 0, '0, ncyc);
        chk("mov_r2_cyc", ncyc, 4);
        run_instr(32'h0000_3007, 0, 0, '0, ncyc);
        chk("mov_r3_pc", PC, 8);
        reset = 1'b1; cyc(); reset = 1'b0;
        chk("rst2_pc", PC, 0);

        // ADD r1 = r2 + r3
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
        run_instr(32'h0002_1003, 0, 0, '0, ncyc);
        chk("add_cyc", ncyc, 4);
        chk("add_pc", PC, 4);
        chk("add_flags", ALUFlags, 4'b0000);
        chk("add_instr", Instr, 32'h0002_1003);

        // STR r1,[r2,#0xFB] -> address 0x100, data 12
        set_ctl(2'b01, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0);
        run_instr(32'h0002_10FB, 0, 0, '0, ncyc);
        chk("str_cyc", ncyc, 4);
        chk("str_we", saw_we, 1);
        chk("str_wdata_r1", wdata_seen, 32'd12);
        chk("str_addr", addr_seen, 32'h100);

        // LDR r4,[r2,#0xFB] with three wait states
        set_ctl(2'b01, 1'b1, 1'b1, 2'b00, 2'b01, 1'b1, 3'b000, 1'b1, 1'b1);
        run_instr(32'h0002_40FB, 0, 3, 32'hDEAD_BEEF, ncyc);
        chk("ldr_cyc", ncyc, 8);
        chk("ldr_addr", addr_seen, 32'h100);
        chk("ldr_addr_stable", addr_moved, 0);
        chk("ldr_no_we", saw_we, 0);
        chk("ldr_pc", PC, 32'hC);

        // STR r4 exposes the loaded value
        set_ctl(2'b01, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0);
        run_instr(32'h0002_40FB, 0, 0, '0, ncyc);
        chk("str_wdata_r4", wdata_seen, 32'hDEAD_BEEF);

        // STR with failed condition
        set_ctl(2'b01, 1'b0, 1'b0, 2'b10, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0);
        run_instr(32'h0002_10FB, 0, 0, '0, ncyc);
        chk("cfail_cyc", ncyc, 2);
        chk("cfail_no_we", saw_we, 0);
        chk("cfail_state", state, S_FETCH);
        chk("cfail_pc", PC, 32'h14);

        // SUB r5 = 5 - 7 -> negative, borrow
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1);
        run_instr(32'h0002_5003, 0, 0, '0, ncyc);
        chk("sub_neg_flags", ALUFlags, 4'b1000);
        chk("sub_neg_pc", PC, 32'h18);

        // MOV r15,#0x20 at 0x18 loads the PC through write-back
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 3'b101, 1'b0, 1'b1);
        run_instr(32'h0000_F020, 0, 0, '0, ncyc);
        chk("mov_pc_cyc", ncyc, 4);
        chk("mov_pc_val", PC, 32'h20);

        // Branch at 0x20, offset +8 from PC+8 -> 0x30
        set_ctl(2'b10, 1'b0, 1'b1, 2'b01, 2'b10, 1'b1, 3'b000, 1'b0, 1'b0);
        run_instr(32'h0A00_0002, 0, 0, '0, ncyc);
        chk("br_cyc", ncyc, 3);
        chk("br_pc", PC, 32'h30);
        chk("br_no_wb", saw_wb, 0);
        chk("br_flags", ALUFlags, 4'b0000);

        // SUB r5 = r2 - r2 -> zero with carry
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b001, 1'b0, 1'b1);
        run_instr(32'h0002_5002, 0, 0, '0, ncyc);
        chk("sub_zero_flags", ALUFlags, 4'b0110);

        // MOV r15,#-4 (sign-extended imm12), then PC wraps to 0 on the next fetch
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b11, 1'b1, 3'b101, 1'b0, 1'b1);
        run_instr(32'h0000_FFFC, 0, 0, '0, ncyc);
        chk("sext_pc", PC, 32'hFFFF_FFFC);
        chk("sext_flags", ALUFlags, 4'b1000);
        chk("wrap_fetch_addr", mem_addr, 32'hFFFF_FFFC);
        set_ctl(2'b00, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        run_instr(32'h0000_0000, 0, 0, '0, ncyc);
        chk("wrap_pc", PC, 0);

        // Reset in the middle of a store
        set_ctl(2'b01, 1'b0, 1'b1, 2'b10, 2'b01, 1'b1, 3'b000, 1'b0, 1'b0);
        mem_rdata = 32'h0002_10FB; mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc(); cyc();
        chk("memwr_state", state, S_MEMWR);
        chk("memwr_we", mem_we, 1);
        reset = 1'b1;
        cyc();
        chk("rst_mid_req", mem_req, 0);
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_state", state, S_FETCH);
        chk("rst_mid_pc", PC, 0);

        // Memory never ready in FETCH
        set_ctl(2'b00, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b0);
        mem_ready = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 14; i++) cyc();
        chk("wait14_state", state, S_FETCH);
        chk("wait14_fault", fault, 0);
        cyc();
`ifdef WAIT_TIMEOUT_EN
        chk("timeout_state", state, S_HALT);
        chk("timeout_fault", fault, 1);
`else
        for (int i = 0; i < 10; i++) cyc();
        chk("nowait_state", state, S_FETCH);
        chk("nowait_fault", fault, 0);
        chk("nowait_req", mem_req, 1);
`endif

        // Undefined instruction class halts with fault until reset
        reset = 1'b1; cyc(); reset = 1'b0;
        set_ctl(2'b11, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 3'b000, 1'b0, 1'b1);
        mem_rdata = 32'hFFFF_FFFF; mem_ready = 1'b1;
        cyc();
        chk("und_decode", state, S_DECODE);
        chk("und_instr", Instr, 32'hFFFF_FFFF);
        cyc();
        chk("und_halt", state, S_HALT);
        chk("und_fault", fault, 1);
        for (int i = 0; i < 3; i++) cyc();
        chk("halt_stays", state, S_HALT);
        chk("halt_no_req", mem_req, 0);
        chk("halt_pc", PC, 4);
        reset = 1'b1;
        cyc();
        chk("halt_rst_fault", fault, 0);
        chk("halt_rst_state", state, S_FETCH);
        chk("halt_rst_instr", Instr, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
